// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if
//   Groups the upstream (ex_*), data-memory (mem_*) and writeback (wb_*)
//   signals of the memory-access pipeline stage.
//   slave  : the mem_stage itself (consumes ex_*, drives mem_*/wb_*)
//   master : the surrounding environment (drives ex_*, memory response)
//
//   ex_valid/ex_ALUop/ex_result/ex_store_data/ex_dst/ex_we/flush  upstream op
//   stall                                                         hold upstream
//   mem_req/mem_wr/mem_addr/mem_wdata                             memory request
//   mem_rdata/mem_ready                                           memory response
//   wb_valid/wb_data/wb_dst/wb_we                                 writeback record
//   mem_err                                                       timeout pulse
// ---------------------------------------------------------------------------
interface mem_stage_if #(
    parameter int unsigned REG_W = 4
);
    logic             ex_valid;
    logic [3:0]       ex_ALUop;
    logic [15:0]      ex_result;
    logic [15:0]      ex_store_data;
    logic [REG_W-1:0] ex_dst;
    logic             ex_we;
    logic             flush;
    logic             stall;

    logic             mem_req;
    logic             mem_wr;
    logic [15:0]      mem_addr;
    logic [15:0]      mem_wdata;
    logic [15:0]      mem_rdata;
    logic             mem_ready;

    logic             wb_valid;
    logic [15:0]      wb_data;
    logic [REG_W-1:0] wb_dst;
    logic             wb_we;
    logic             mem_err;

    modport slave (
        input  ex_valid, ex_ALUop, ex_result, ex_store_data, ex_dst, ex_we, flush,
        input  mem_rdata, mem_ready,
        output stall, mem_req, mem_wr, mem_addr, mem_wdata,
        output wb_valid, wb_data, wb_dst, wb_we, mem_err
    );

    modport master (
        output ex_valid, ex_ALUop, ex_result, ex_store_data, ex_dst, ex_we, flush,
        output mem_rdata, mem_ready,
        input  stall, mem_req, mem_wr, mem_addr, mem_wdata,
        input  wb_valid, wb_data, wb_dst, wb_we, mem_err
    );
endinterface

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//   Memory-access pipeline stage after the ALU. LW/SW use the ALU result as
//   the effective address and perform one access on a single-port data memory
//   over a req/ready handshake; every other opcode passes the ALU result
//   straight through to a registered writeback record (latency 1).
//   While an access is outstanding the stage is BUSY: stall and mem_req are
//   high and upstream inputs are ignored.
//
//   Ports
//     clk  : clock, all state on rising edge
//     rst  : synchronous active-high reset
//     bus  : mem_stage_if.slave (upstream op, memory handshake, writeback)
//
//   Parameters
//     REG_W          : destination register index width
//     TIMEOUT_CYCLES : BUSY cycles without ready before an access is aborted
//
//   Build option
//     MEM_TIMEOUT_EN : when defined, an access with no ready for
//                      TIMEOUT_CYCLES BUSY cycles is aborted and mem_err
//                      pulses with a wb_we=0 writeback record. Undefined:
//                      BUSY waits indefinitely and mem_err is tied low.
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int unsigned REG_W          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    mem_stage_if.slave bus
);

    localparam logic [3:0] OP_LW = 4'b1000;
    localparam logic [3:0] OP_SW = 4'b1001;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             wr_q, wr_d;
    logic [REG_W-1:0] dst_q, dst_d;
    logic             we_q, we_d;

    logic             wb_valid_q, wb_valid_d;
    logic [15:0]      wb_data_q, wb_data_d;
    logic [REG_W-1:0] wb_dst_q, wb_dst_d;
    logic             wb_we_q, wb_we_d;

    logic             accept;
    logic             is_mem;
    logic             timeout_hit;

    assign accept = bus.ex_valid & ~bus.flush & (state_q == IDLE);
    assign is_mem = (bus.ex_ALUop == OP_LW) | (bus.ex_ALUop == OP_SW);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             mem_err_q;

    // cnt_q counts completed BUSY cycles without ready, so the abort fires
    // during the TIMEOUT_CYCLES-th BUSY cycle; ready in that cycle wins.
    assign timeout_hit = (state_q == BUSY) & ~bus.mem_ready & (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            mem_err_q <= timeout_hit;
            if (accept && is_mem) begin
                cnt_q <= '0;
            end else if ((state_q == BUSY) && !bus.mem_ready && !timeout_hit) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.mem_err = mem_err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign bus.mem_err        = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        dst_d      = dst_q;
        we_d       = we_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_dst_d   = wb_dst_q;
        wb_we_d    = wb_we_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_mem) begin
                        state_d = BUSY;
                        addr_d  = bus.ex_result;
                        wdata_d = bus.ex_store_data;
                        wr_d    = (bus.ex_ALUop == OP_SW);
                        dst_d   = bus.ex_dst;
                        we_d    = bus.ex_we;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = bus.ex_result;
                        wb_dst_d   = bus.ex_dst;
                        wb_we_d    = bus.ex_we;
                    end
                end
            end
            BUSY: begin
                if (bus.mem_ready) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_dst_d   = dst_q;
                    if (wr_q) begin
                        // A store reports its address and never writes a register.
                        wb_data_d = addr_q;
                        wb_we_d   = 1'b0;
                    end else begin
                        wb_data_d = bus.mem_rdata;
                        wb_we_d   = we_q;
                    end
                end else if (timeout_hit) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_data_d  = addr_q;
                    wb_dst_d   = dst_q;
                    wb_we_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            dst_q      <= '0;
            we_q       <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_dst_q   <= '0;
            wb_we_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            dst_q      <= dst_d;
            we_q       <= we_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_dst_q   <= wb_dst_d;
            wb_we_q    <= wb_we_d;
        end
    end

    // Request fields come straight from the latched op, so they stay stable
    // for as long as the request is held.
    assign bus.stall     = (state_q == BUSY);
    assign bus.mem_req   = (state_q == BUSY);
    assign bus.mem_wr    = wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.wb_dst    = wb_dst_q;
    assign bus.wb_we     = wb_we_q;

endmodule
